// File: rtl/fdiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : fdiv_iter
//  Purpose  : Iterative single-precision divider y = x1 / x2 using restoring
//             division (one quotient bit per cycle, 26 bits, fixed latency).
//             Denormals read as zero, underflow flushes to zero, x/0 -> Inf.
//  Revision : 1.0  initial release
// ============================================================================
module fdiv_iter (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter value on the edge that performs the 26th quotient iteration.
    localparam logic [4:0] c_LAST_ITER = 5'd25;

    state_t      state_q, state_d;
    logic        s_q, s_d;
    logic [7:0]  e1_q, e1_d;
    logic [7:0]  e2_q, e2_d;
    logic [23:0] mb_q, mb_d;
    logic [24:0] r_q, r_d;
    logic [25:0] q_q, q_d;
    logic        z1_q, z1_d;
    logic        z2_q, z2_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] y_q, y_d;
    logic        out_valid_q, out_valid_d;

    logic [24:0] w_diff;
    logic [22:0] w_m;
    logic        w_g;
    logic [23:0] w_mr;
    logic [9:0]  w_e;
    logic [31:0] w_y;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign y         = y_q;

    // Normalise the raw quotient, round half-up, and apply result priority.
    always_comb begin
        w_e = {2'b00, e1_q} - {2'b00, e2_q} + (q_q[25] ? 10'd127 : 10'd126);
        if (q_q[25]) begin
            w_m = q_q[24:2];
            w_g = q_q[1];
        end else begin
            w_m = q_q[23:1];
            w_g = q_q[0];
        end
        w_mr = {1'b0, w_m} + {23'd0, w_g};
        // A carry out of the mantissa leaves w_mr[22:0] zero; only bump e.
        if (w_mr[23]) begin
            w_e = w_e + 10'd1;
        end
        if (z2_q) begin
            w_y = {s_q, 8'hFF, 23'd0};
        end else if (z1_q) begin
            w_y = {s_q, 31'd0};
        end else if (!w_e[9] && (w_e >= 10'd255)) begin
            w_y = {s_q, 8'hFF, 23'd0};
        end else if (w_e[9] || (w_e == 10'd0)) begin
            w_y = {s_q, 31'd0};
        end else begin
            w_y = {s_q, w_e[7:0], w_mr[22:0]};
        end
    end

    // Next-state and datapath update for the IDLE/DIV/NORM/DONE sequence.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        e1_d        = e1_q;
        e2_d        = e2_q;
        mb_d        = mb_q;
        r_d         = r_q;
        q_d         = q_q;
        z1_d        = z1_q;
        z2_d        = z2_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        w_diff      = r_q - {1'b0, mb_q};
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    s_d     = x1[31] ^ x2[31];
                    e1_d    = x1[30:23];
                    e2_d    = x2[30:23];
                    mb_d    = {1'b1, x2[22:0]};
                    r_d     = {1'b0, 1'b1, x1[22:0]};
                    q_d     = 26'd0;
                    z1_d    = (x1[30:23] == 8'd0);
                    z2_d    = (x2[30:23] == 8'd0);
                    cnt_d   = 5'd0;
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                // r stays below 2*mb, so the shifted value always fits 25 bits.
                if (r_q >= {1'b0, mb_q}) begin
                    q_d = {q_q[24:0], 1'b1};
                    r_d = {w_diff[23:0], 1'b0};
                end else begin
                    q_d = {q_q[24:0], 1'b0};
                    r_d = {r_q[23:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == c_LAST_ITER) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                y_d         = w_y;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; asynchronous reset aborts any divide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            s_q         <= 1'b0;
            e1_q        <= 8'd0;
            e2_q        <= 8'd0;
            mb_q        <= 24'd0;
            r_q         <= 25'd0;
            q_q         <= 26'd0;
            z1_q        <= 1'b0;
            z2_q        <= 1'b0;
            cnt_q       <= 5'd0;
            y_q         <= 32'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            e1_q        <= e1_d;
            e2_q        <= e2_d;
            mb_q        <= mb_d;
            r_q         <= r_d;
            q_q         <= q_d;
            z1_q        <= z1_d;
            z2_q        <= z2_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fdiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fdiv_iter
//  Purpose  : Scoreboard bench for fdiv_iter: directed and random divides,
//             backpressure, and asynchronous reset during an operation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fdiv_iter;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;

    fdiv_iter dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    typedef struct {
        logic [31:0] y;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ready_mode = 0;   // 0: always ready, 1: stalled, 2: random

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle count used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: exact integer quotient, then the number-format rules.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, e;
        longint ma, mb, q, m, g, mr;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (eb == 0) return {s, 8'hFF, 23'd0};
        if (ea == 0) return {s, 31'd0};
        ma = longint'({40'd0, 1'b1, a[22:0]});
        mb = longint'({40'd0, 1'b1, b[22:0]});
        q  = (ma << 25) / mb;
        if (q >= 64'sd33554432) begin
            m = (q >> 2) & 64'h7FFFFF;
            g = (q >> 1) & 64'h1;
            e = ea - eb + 127;
        end else begin
            m = (q >> 1) & 64'h7FFFFF;
            g = q & 64'h1;
            e = ea - eb + 126;
        end
        mr = m + g;
        if (mr == 64'sd8388608) begin
            mr = 0;
            e  = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, e[7:0], mr[22:0]};
    endfunction

    // Issue one divide and push its expected result at the accepting edge.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
            return;
        end
        in_valid = 1'b1;
        x1 = a;
        x2 = b;
        @(posedge clk);
        #1;
        exp_q.push_back('{exp, cyc});
        in_valid = 1'b0;
        x1 = $urandom;
        x2 = $urandom;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Consumer-side ready generation.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: latency on out_valid rising, value on each handshake.
    initial begin
        logic prev_ov;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov && exp_q.size() != 0)
                    chk("latency", cyc - exp_q[0].acc, 27);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output y=%h required=none", y);
                    end else begin
                        chk("y", y, exp_q[0].y);
                        void'(exp_q.pop_front());
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        logic [31:0] a, b, y_hold;
        int          busy_bad, n;
        rstn     = 1'b0;
        in_valid = 1'b0;
        x1       = 32'd0;
        x2       = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_y", y, 32'd0);
        rstn = 1'b1;

        // Basic divide with in_ready watched throughout the operation.
        do_div(32'h40C00000, 32'h40000000, 32'h40400000);
        busy_bad = 0;
        repeat (27) begin
            @(negedge clk);
            if (in_ready || out_valid) busy_bad++;
        end
        chk("busy_flags", busy_bad, 0);

        do_div(32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
        do_div(32'hBF800000, 32'h40000000, 32'hBF000000);
        do_div(32'h3F800000, 32'h00000000, 32'h7F800000);
        do_div(32'h00000000, 32'hC0000000, 32'h80000000);
        do_div(32'h00400000, 32'h3F800000, 32'h00000000);
        do_div(32'h7F000000, 32'h3E800000, 32'h7F800000);
        do_div(32'h00800000, 32'h40000000, 32'h00000000);
        wait_drain();

        // Backpressure: stall the consumer and poke in_valid while busy.
        ready_mode = 1;
        @(negedge clk);
        do_div(32'h41100000, 32'h40400000, 32'h40400000);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", {31'd0, out_valid}, 1);
        y_hold = y;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x1 = $urandom;
            x2 = $urandom;
            chk("bp_hold", {y, 3'd0, out_valid, 3'd0, in_ready}, {y_hold, 4'h1, 4'h0});
        end
        @(negedge clk);
        in_valid   = 1'b0;
        ready_mode = 0;
        n = 0;
        while (out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("bp_release", {y, 3'd0, out_valid, 3'd0, in_ready}, {y_hold, 4'h0, 4'h1});
        do_div(32'h42C80000, 32'h41200000, 32'h41200000);
        wait_drain();

        // Random operands, exponents biased so most results stay in range.
        ready_mode = 2;
        for (int i = 0; i < 120; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) != 0) b[30:23] = 8'($urandom_range(100, 154));
            if ($urandom_range(0, 3) != 0) a[30:23] = 8'($urandom_range(100, 154));
            if ($urandom_range(0, 15) == 0) b[30:23] = 8'd0;
            if ($urandom_range(0, 15) == 0) a[30:23] = 8'd0;
            do_div(a, b, ref_div(a, b));
        end
        wait_drain();
        ready_mode = 0;

        // Asynchronous reset at iteration 12 aborts the operation.
        do_div(32'h40E00000, 32'h40400000, ref_div(32'h40E00000, 32'h40400000));
        repeat (12) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
        chk("mid_rst_y", y, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_stale_output", {31'd0, out_valid}, 0);
        do_div(32'h41200000, 32'h40A00000, 32'h40000000);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
